schoolbook_seq: RTL and testbench
=================================

# schoolbook_seq

Parametrised sequential schoolbook multiplier: it computes c = a × b for unsigned operands of independent widths A_W and B_W. Each cycle it consumes DIGIT bits of the multiplier, so the cost is one partial-product adder per digit.
- Operands are captured on a start/done handshake.
- The result stays registered until the next completion.
- It is the next generation of the bit-serial schoolbook multiplier in the large-integer library. It adds generic widths, a multi-bit digit, explicit handshake and optional early termination.

## Interface
- A_W, default 384: multiplicand width in bits (≥1).
- B_W, default 384: multiplier width in bits (≥1).
- DIGIT, default 4: multiplier bits processed per cycle (1 ≤ DIGIT ≤ B_W). N = ceil(B_W/DIGIT) is the number of steps.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- a  input  A_W  multiplicand; sampled with an accepted start.
- b  input  B_W  multiplier; sampled with an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; c is updated to the new product on the same edge.
- c  output  A_W+B_W  product register; holds the last completed result.

## Operation
- States: IDLE and RUN.
- IDLE: busy=0.
  - start=1 at a rising edge → capture a into a_reg and b (zero-extended to N·DIGIT bits) into b_sh.
  - The same edge clears acc, clears the step index k, and moves to RUN.
- RUN: busy=1. Each edge:
  - acc ← acc + ((a_reg × b_sh[DIGIT-1:0]) << (k·DIGIT));
  - b_sh ← b_sh >> DIGIT;
  - k ← k+1.
- Completion edge (k = N-1 in the default build): c ← final acc value including this step's partial product, done ← 1, state → IDLE.
- Width rules:
  - acc and c are A_W+B_W bits.
  - Every partial sum is ≤ the final product, so no overflow and no truncation is possible.
  - Padded multiplier bits are zero and contribute nothing.
  - The partial product a_reg × digit is A_W+DIGIT bits.
- start while busy=1 is ignored; a and b are not sampled. The running operation completes with its original operands.
- start held high continuously: a new operation is accepted on the edge after the done edge (state is IDLE while done=1).
- c changes only on completion edges and reset. Between completions c holds its value regardless of start, a and b.

## Timing
- Reset (asynchronous, immediate): c=0, done=0, busy=0, state=IDLE, acc=0, k=0, a_reg=0, b_sh=0.
- Reset during RUN aborts the operation. No done pulse occurs, and c reads 0 afterwards.
- Start accepted at edge E0 → busy=1 from E0.
- Default build: steps at edges E1..EN.
  - done=1 and the new c are visible after EN.
  - busy=0 after EN.
  - Latency N cycles.
  - Minimum start-to-start spacing N+1 cycles.
- done is high for exactly one cycle per completed operation. It is never asserted while busy=1.
- For N=1, the completion edge is E1.

## Configuration
- SCHOOLBOOK_SEQ_EARLY_DONE_EN defined:
  - A RUN edge is also a completion edge if the post-shift b_sh is all zero; acc already equals the full product then.
  - Latency = max(1, ceil(msb_index(b)+1 / DIGIT)) cycles.
  - b=0 completes at E1 with c=0.
- Not defined: latency is always exactly N cycles, independent of operand values.

## Test plan
- Default parameters, no macro:
  - a=3, b=5, start pulse at E0 → busy after E0; done pulse after E96; c=15.
  - With SCHOOLBOOK_SEQ_EARLY_DONE_EN defined: same stimulus → done after E1, c=15.
- a=b=2^384−1 → c = 2^768 − 2^385 + 1; done after exactly E96 under either macro setting.
- A_W=17, B_W=10, DIGIT=4 (N=3): a=0x1FFFF, b=0x3FF → c=0x7FDFC01, done after E3.
  - b=0 with the macro defined → c=0, done after E1.
- Start a=7, b=9; pulse start again with a=100, b=100 at E10 while busy → ignored; c=63 after E96; only one done pulse.
- Start a=b=0xFF…F; assert rst asynchronously mid-cycle between E40 and E41 → c=0, busy=0, done=0 immediately and with no later pulse. A fresh start with a=2, b=3 then yields c=6 after N cycles.
- start held at 1 for 3 operations (a=1,2,3; b=4) → done pulses at E96, E193, E290; c=4, 8, 12.

Source files
------------

// File: rtl/schoolbook_seq.sv
// Sequential schoolbook multiplier: c = a * b, consuming DIGIT multiplier bits per cycle.
// Optional early termination on an exhausted multiplier: define SCHOOLBOOK_SEQ_EARLY_DONE_EN.
module schoolbook_seq #(
    parameter int A_W   = 384,
    parameter int B_W   = 384,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [A_W+B_W-1:0] c
);

    localparam int N     = (B_W + DIGIT - 1) / DIGIT;
    localparam int PAD_W = N * DIGIT;
    localparam int P_W   = A_W + B_W;
    localparam int PP_W  = A_W + DIGIT;
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [A_W-1:0]     a_reg;
    logic [PAD_W-1:0]   b_sh;
    logic [P_W-1:0]     acc;
    logic [K_W-1:0]     k;

    logic [PP_W-1:0]    pp;
    logic [P_W-1:0]     acc_next;
    logic [PAD_W-1:0]   b_next;
    logic               last;

    // Both multiplier operands are widened first so the product is not truncated to A_W bits.
    always_comb begin
        pp       = PP_W'(a_reg) * PP_W'(b_sh[DIGIT-1:0]);
        acc_next = acc + (P_W'(pp) << (k * DIGIT));
        b_next   = b_sh >> DIGIT;
        last     = (k == K_W'(N - 1));
`ifdef SCHOOLBOOK_SEQ_EARLY_DONE_EN
        // Remaining multiplier digits are all zero, so acc_next is already the full product.
        if (b_next == '0) begin
            last = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the update order inside this block does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            c     <= '0;
            acc   <= '0;
            k     <= '0;
            a_reg <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_sh  <= PAD_W'(b);
                        acc   <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    b_sh <= b_next;
                    k    <= k + 1'b1;
                    done <= last;
                    if (last) begin
                        c     <= acc_next;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_schoolbook_seq.sv
// Directed self-checking bench for schoolbook_seq: default 384x384/4 instance plus a 17x10/4 instance.
module tb_schoolbook_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         start = 1'b0;
    logic [383:0] a = '0;
    logic [383:0] b = '0;
    logic         busy;
    logic         done;
    logic [767:0] c;

    logic         s_start = 1'b0;
    logic [16:0]  s_a = '0;
    logic [9:0]   s_b = '0;
    logic         s_busy;
    logic         s_done;
    logic [26:0]  s_c;

    int checks   = 0;
    int failures = 0;

    schoolbook_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c)
    );

    schoolbook_seq #(.A_W(17), .B_W(10), .DIGIT(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .c(s_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected latency in cycles for a multiplier value; both instances use DIGIT=4.
    function automatic int exp_lat(input logic [383:0] bv, input int n);
`ifdef SCHOOLBOOK_SEQ_EARLY_DONE_EN
        int m = -1;
        for (int i = 0; i < 384; i++) if (bv[i]) m = i;
        if (m < 0) return 1;
        return (m + 1 + 3) / 4;
`else
        return n;
`endif
    endfunction

    // Called #1 after an edge: launch one operation and follow it to completion.
    task automatic run_big(input string name, input logic [383:0] av, input logic [383:0] bv,
                           input logic [767:0] cv);
        int lat, cyc;
        bit held;
        logic [767:0] prev;
        lat = exp_lat(bv, 96);
        start = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '0;
        check({name, " busy_at_e0"}, 768'(busy), 768'd1);
        prev = c; held = 1'b1; cyc = 0;
        while (cyc <= lat + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (c !== prev) held = 1'b0;
        end
        check({name, " latency"}, 768'(cyc), 768'(lat));
        check({name, " c"}, c, cv);
        check({name, " c_held_while_busy"}, 768'(held), 768'd1);
        check({name, " busy_at_done"}, 768'(busy), 768'd0);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, 768'(done), 768'd0);
    endtask

    task automatic run_small(input string name, input logic [16:0] av, input logic [9:0] bv,
                             input logic [26:0] cv);
        int lat, cyc;
        lat = exp_lat(384'(bv), 3);
        s_start = 1'b1; s_a = av; s_b = bv;
        @(posedge clk); #1;
        s_start = 1'b0;
        check({name, " busy_at_e0"}, 768'(s_busy), 768'd1);
        cyc = 0;
        while (cyc <= lat + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (s_done) break;
        end
        check({name, " latency"}, 768'(cyc), 768'(lat));
        check({name, " c"}, 768'(s_c), 768'(cv));
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, 768'(s_done), 768'd0);
    endtask

    typedef struct {
        string        name;
        logic [383:0] a;
        logic [383:0] b;
        logic [767:0] c;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [767:0] all1_prod;
        logic [383:0] bb;
        logic [767:0] cc;
        int lat, cyc, pulses, j;

        all1_prod = '0;
        all1_prod = all1_prod - (768'd1 << 385) + 768'd1;
        vecs[0] = '{"a3_b5",      384'd3,          384'd5,     768'd15};
        vecs[1] = '{"a0_b123",    384'd0,          384'd123,   768'd0};
        vecs[2] = '{"a123_b0",    384'd123,        384'd0,     768'd0};
        vecs[3] = '{"all_ones",   '1,              '1,         all1_prod};
        vecs[4] = '{"pow2",       384'd1 << 100,   384'd1 << 200, 768'd1 << 300};
        vecs[5] = '{"dec",        384'd12345,      384'd1000,  768'd12345000};
        vecs[6] = '{"ffff_10001", 384'hFFFF,       384'h10001, 768'hFFFF_FFFF};

        // Asynchronous reset without any clock edge involved.
        #2 rst = 1'b1;
        #1;
        check("reset c", c, 768'd0);
        check("reset busy", 768'(busy), 768'd0);
        check("reset done", 768'(done), 768'd0);
        check("reset small c", 768'(s_c), 768'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_big(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c);

        run_small("small_max", 17'h1FFFF, 10'h3FF, 27'h7FDFC01);
        run_small("small_b0", 17'h1FFFF, 10'h0, 27'h0);

        // Second start while busy must be ignored.
        bb = 384'd9;
        cc = 768'd63;
`ifdef SCHOOLBOOK_SEQ_EARLY_DONE_EN
        bb = bb << 300;
        cc = cc << 300;
`endif
        lat = exp_lat(bb, 96);
        start = 1'b1; a = 384'd7; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; cyc = 0;
        for (int e = 1; e <= lat + 20; e++) begin
            if (e == 10) begin
                start = 1'b1; a = 384'd100; b = 384'd100;
            end
            @(posedge clk); #1;
            if (e == 10) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) cyc = e;
            end
        end
        check("ignore done_count", 768'(pulses), 768'd1);
        check("ignore latency", 768'(cyc), 768'(lat));
        check("ignore c", c, cc);

        // Asynchronous reset mid-run aborts with no later done pulse.
        lat = exp_lat('1, 96);
        start = 1'b1; a = '1; b = '1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        check("abort c", c, 768'd0);
        check("abort busy", 768'(busy), 768'd0);
        check("abort done", 768'(done), 768'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        pulses = 0;
        for (int e = 0; e < lat + 10; e++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        check("abort no_done", 768'(pulses), 768'd0);
        run_big("after_abort", 384'd2, 384'd3, 768'd6);

        // start held high: back-to-back operations a=1,2,3 with b=4.
        lat = exp_lat(384'd4, 96);
        start = 1'b1; a = 384'd1; b = 384'd4;
        @(posedge clk); #1;
        check("held busy_at_e0", 768'(busy), 768'd1);
        j = 0;
        for (int e = 1; e <= 3 * lat + 20 && j < 3; e++) begin
            @(posedge clk); #1;
            if (done) begin
                check($sformatf("held op%0d edge", j), 768'(e), 768'(lat * (j + 1) + j));
                check($sformatf("held op%0d c", j), c, 768'(4 * (j + 1)));
                j++;
                a = 384'(j + 1);
                if (j == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held op_count", 768'(j), 768'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
